sequence_pattern_generator: RTL and testbench

//  Serial bit-pattern transmitter: the producer side of the single-bit `a` stream consumed by sequence_detector.
//  - Latches a W-bit pattern and a repeat count on start.
//  - Emits the pattern MSB-first, one bit per clk, REPS times, with optional GAP idle cycles between repetitions.
//  - Drives the detector's `a` input in system benches and on-chip self-test.

---
 rtl/sequence_pattern_generator_pkg.sv | 12 +
 rtl/sequence_pattern_generator_if.sv | 26 ++
 rtl/sequence_pattern_generator_piso_shift.sv | 32 +++
 rtl/sequence_pattern_generator.sv | 120 ++++++++++++
 tb/tb_sequence_pattern_generator.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sequence_pattern_generator_pkg.sv
// Shared types for the serial pattern generator.
// Holds the FSM state encoding used by the top level.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sequence_pattern_generator_if.sv
// Handshake bundle between a pattern requester and the generator.
// Ports: start/pat_in/reps (request), a/valid/busy/done (stream, status).
import seq_gen_pkg::*;

interface sequence_pattern_generator_if #(
    parameter int W  = 4,
    parameter int RW = 4
);
    logic          start;
    logic [W-1:0]  pat_in;
    logic [RW-1:0] reps;
    logic          a;
    logic          valid;
    logic          busy;
    logic          done;

    modport master (
        output start, pat_in, reps,
        input  a, valid, busy, done
    );

    modport slave (
        input  start, pat_in, reps,
        output a, valid, busy, done
    );
endinterface

// File: rtl/sequence_pattern_generator_piso_shift.sv
// W-bit parallel-load register that rotates left on shift (MSB first).
// Ports: clk, rst, i_load, i_shift, i_d; o_msb (current MSB), o_next.
import seq_gen_pkg::*;

module piso_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_d,
    output logic         o_msb,
    output logic         o_next
);
    logic [W-1:0] r_sh;

    // Rotating instead of plain shifting restores the pattern after
    // W shifts, so repetitions need no separate copy of the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_d;
        end else if (i_shift) begin
            r_sh <= {r_sh[W-2:0], r_sh[W-1]};
        end
    end

    assign o_msb  = r_sh[W-1];
    assign o_next = r_sh[W-2];
endmodule

// File: rtl/sequence_pattern_generator.sv
// Serial pattern transmitter: sends pat_in MSB-first reps times.
// Ports: clk, rst (async, active-high), bus (slave modport).
import seq_gen_pkg::*;

module sequence_pattern_generator #(
    parameter int W   = 4,
    parameter int RW  = 4,
    parameter int GAP = 0
) (
    input logic                        clk,
    input logic                        rst,
    sequence_pattern_generator_if.slave bus
);
    localparam int BW = $clog2(W);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t        r_state;
    logic [BW-1:0] r_bit_cnt;
    logic [RW-1:0] r_rep_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_a;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic w_load;
    logic w_shift;
    logic w_msb;
    logic w_next;

    assign w_load  = (r_state == ST_IDLE) && bus.start;
    assign w_shift = (r_state == ST_SEND);

    piso_shift #(.W(W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_d     (bus.pat_in),
        .o_msb   (w_msb),
        .o_next  (w_next)
    );

    // r_bit_cnt tracks the bit currently on r_a; w_next is the bit
    // that reaches the register MSB after this edge's rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
            r_a       <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.reps != '0) begin
                            r_state   <= ST_SEND;
                            r_bit_cnt <= BW'(W - 1);
                            r_rep_cnt <= bus.reps - 1'b1;
                            r_a       <= bus.pat_in[W-1];
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                        r_a       <= w_next;
                    end else if (r_rep_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_a     <= 1'b0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_rep_cnt <= r_rep_cnt - 1'b1;
                        r_bit_cnt <= BW'(W - 1);
                        if (GAP > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GW'(GAP - 1);
                            r_a       <= 1'b0;
                            r_valid   <= 1'b0;
                        end else begin
                            r_a <= w_next;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_SEND;
                        r_a     <= w_msb;
                        r_valid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a     = r_a;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_sequence_pattern_generator.sv
// Directed bench for sequence_pattern_generator (GAP=0 and GAP=2).
// Ports: none; drives two DUT instances through their interfaces.
module tb_sequence_pattern_generator;
    logic clk;
    logic rst;

    int n_cmp;
    int n_bad;

    logic [15:0] cap_a;
    logic [15:0] cap_v;
    logic [15:0] cap_b;
    logic [15:0] cap_d;

    sequence_pattern_generator_if #(.W(4), .RW(4)) if0 ();
    sequence_pattern_generator_if #(.W(4), .RW(4)) if1 ();

    sequence_pattern_generator #(.W(4), .RW(4), .GAP(0)) u_g0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    sequence_pattern_generator #(.W(4), .RW(4), .GAP(2)) u_g2 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {a, valid, busy, done}
    function automatic logic [3:0] get(input int which);
        if (which == 0)
            return {if0.a, if0.valid, if0.busy, if0.done};
        return {if1.a, if1.valid, if1.busy, if1.done};
    endfunction

    task automatic set_in(input int which, input logic st,
                          input logic [3:0] pat, input logic [3:0] rp);
        if (which == 0) begin
            if0.start = st; if0.pat_in = pat; if0.reps = rp;
        end else begin
            if1.start = st; if1.pat_in = pat; if1.reps = rp;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int which, input logic [3:0] pat,
                          input logic [3:0] rp);
        set_in(which, 1'b1, pat, rp);
        tick();
        set_in(which, 1'b0, pat, rp);
    endtask

    // Records n cycles after the start edge; first cycle lands in the
    // MSB of the n-bit window. inj[i] pulses start during cycle i.
    task automatic capture(input int which, input int n,
                           input logic [15:0] inj,
                           input logic [3:0] alt_pat,
                           input logic [3:0] alt_reps);
        logic [3:0] s;
        cap_a = '0; cap_v = '0; cap_b = '0; cap_d = '0;
        for (int i = 1; i <= n; i++) begin
            s = get(which);
            cap_a = {cap_a[14:0], s[3]};
            cap_v = {cap_v[14:0], s[2]};
            cap_b = {cap_b[14:0], s[1]};
            cap_d = {cap_d[14:0], s[0]};
            set_in(which, inj[i], alt_pat, alt_reps);
            tick();
        end
        set_in(which, 1'b0, alt_pat, alt_reps);
    endtask

    initial begin
        int busy_n;
        int ones_n;
        int done_n;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        set_in(0, 1'b1, 4'b1111, 4'd1);
        set_in(1, 1'b1, 4'b1111, 4'd1);

        // reset held with start high
        tick();
        chk("rst_c1_g0", get(0), 4'b0000);
        chk("rst_c1_g2", get(1), 4'b0000);
        tick();
        chk("rst_c2_g0", get(0), 4'b0000);
        rst = 1'b0;
        set_in(0, 1'b0, 4'b1111, 4'd1);
        set_in(1, 1'b0, 4'b1111, 4'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_idle", get(0), 4'b0000);
        end

        // single pattern
        launch(0, 4'b1001, 4'd1);
        capture(0, 6, 16'h0, 4'b0000, 4'd0);
        chk("single_a", cap_a, 16'b100100);
        chk("single_v", cap_v, 16'b111100);
        chk("single_b", cap_b, 16'b111100);
        chk("single_d", cap_d, 16'b000010);

        // back-to-back repetitions
        launch(0, 4'b1001, 4'd2);
        capture(0, 10, 16'h0, 4'b0000, 4'd0);
        chk("b2b_a", cap_a, 16'b1001100100);
        chk("b2b_v", cap_v, 16'b1111111100);
        chk("b2b_b", cap_b, 16'b1111111100);
        chk("b2b_d", cap_d, 16'b0000000010);

        // gap insertion
        launch(1, 4'b1100, 4'd2);
        capture(1, 12, 16'h0, 4'b0000, 4'd0);
        chk("gap_a", cap_a, 16'b110000110000);
        chk("gap_v", cap_v, 16'b111100111100);
        chk("gap_b", cap_b, 16'b111111111100);
        chk("gap_d", cap_d, 16'b000000000010);

        // gap instance with one repetition never enters GAP
        launch(1, 4'b1001, 4'd1);
        capture(1, 6, 16'h0, 4'b0000, 4'd0);
        chk("gap1_a", cap_a, 16'b100100);
        chk("gap1_b", cap_b, 16'b111100);
        chk("gap1_d", cap_d, 16'b000010);

        // zero repetitions
        launch(0, 4'b1111, 4'd0);
        capture(0, 3, 16'h0, 4'b1111, 4'd0);
        chk("zero_a", cap_a, 16'b000);
        chk("zero_v", cap_v, 16'b000);
        chk("zero_b", cap_b, 16'b000);
        chk("zero_d", cap_d, 16'b100);

        // start during SEND (cycle 2) and during DONE (cycle 5)
        launch(0, 4'b1010, 4'd1);
        capture(0, 7, 16'b0000_0000_0010_0100, 4'b0101, 4'd3);
        chk("ign_a", cap_a, 16'b1010000);
        chk("ign_v", cap_v, 16'b1111000);
        chk("ign_b", cap_b, 16'b1111000);
        chk("ign_d", cap_d, 16'b0000100);

        // asynchronous reset during bit 2 of a 3-rep run
        launch(0, 4'b1011, 4'd3);
        chk("mid_bit1", get(0), 4'b1110);
        tick();
        chk("mid_bit2", get(0), 4'b0110);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async", get(0), 4'b0000);
        tick();
        chk("mid_held", get(0), 4'b0000);
        rst = 1'b0;
        tick();
        chk("mid_idle", get(0), 4'b0000);
        launch(0, 4'b1011, 4'd1);
        capture(0, 6, 16'h0, 4'b0000, 4'd0);
        chk("fresh_a", cap_a, 16'b101100);
        chk("fresh_v", cap_v, 16'b111100);
        chk("fresh_d", cap_d, 16'b000010);

        // maximum repetition count
        launch(0, 4'b1001, 4'hF);
        busy_n = 0;
        ones_n = 0;
        done_n = 0;
        for (int i = 0; i < 200 && done_n == 0; i++) begin
            if (if0.busy) busy_n++;
            if (if0.a) ones_n++;
            if (if0.done) done_n++;
            tick();
        end
        chk("max_done", done_n, 1);
        chk("max_busy", busy_n, 60);
        chk("max_ones", ones_n, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
